bch_dec_ctrl: RTL and testbench

Sequencing controller for the BCH(15,7), t=2 decoder over GF(16). It accepts one 15-bit received word per valid/ready handshake and drives three datapath units in order:
- the serial syndrome unit;
- the Berlekamp-Massey block (inputs S1/S2/S3, outputs lambda1/lambda2);
- the Chien-search unit.
It counts error hits, flips the corrected bits, flags uncorrectable words, and presents the result on a valid/ready output.

---
 rtl/bch_pkg.sv | 34 +++
 rtl/bch_dec_stats.sv | 28 ++
 rtl/bch_dec_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bch_dec_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared constants, types and helpers for the BCH(15,7) t=2 decoder controller.
package bch_pkg;

    localparam int N = 15;
    localparam int K = 7;
    localparam int M = 4;
    localparam int T = 2;

    localparam logic [1:0]  HIT_SAT  = 2'(T + 1);
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef logic [M-1:0] gf16_t;

    typedef enum logic [2:0] {
        IDLE,
        SYND,
        CHECK,
        BM,
        LOAD,
        CHIEN,
        DONE
    } state_t;

    // Degree of the error-locator polynomial as reported by Berlekamp-Massey.
    function automatic logic [1:0] locator_degree(input gf16_t l1, input gf16_t l2);
        if (l2 != '0) begin
            return 2'd2;
        end else if (l1 != '0) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

endpackage

// File: rtl/bch_dec_stats.sv
// Saturating counters of corrected and failed words, updated on each output handshake.
module bch_dec_stats
    import bch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fire,
    input  logic [1:0]  err_cnt,
    input  logic        fail,
    output logic [15:0] stat_corr,
    output logic [15:0] stat_fail
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_corr <= '0;
            stat_fail <= '0;
        end else if (fire) begin
            if (fail && stat_fail != STAT_MAX) begin
                stat_fail <= stat_fail + 16'd1;
            end
            if (!fail && err_cnt != 2'd0 && stat_corr != STAT_MAX) begin
                stat_corr <= stat_corr + 16'd1;
            end
        end
    end

endmodule

// File: rtl/bch_dec_ctrl.sv
// Sequencing controller for the BCH(15,7) t=2 decoder: syndrome, Berlekamp-Massey, Chien, correction.
// Optional statistics counters are built when BCH_DEC_STATS_EN is defined.
module bch_dec_ctrl
    import bch_pkg::*;
#(
    parameter int BM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          synd_clr,
    output logic          synd_en,
    output logic          synd_bit,
    input  logic [3:0]    S1,
    input  logic [3:0]    S2,
    input  logic [3:0]    S3,
    input  logic [3:0]    lambda1,
    input  logic [3:0]    lambda2,
    output logic          chien_load,
    output logic          chien_en,
    input  logic          err_hit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [1:0]    out_err_cnt,
    output logic          out_fail,
    output logic [15:0]   stat_corr,
    output logic [15:0]   stat_fail
);

    state_t state, state_n;

    logic [N-1:0] raw_word, work_word, work_n, flip_mask, res_data;
    logic [3:0]   cnt, bit_idx;
    logic [2:0]   wait_cnt;
    logic [1:0]   hits, hits_n, degree, res_err_cnt;
    logic         res_fail, fail_n, accept, syn_zero, last_step;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign bit_idx   = 4'(N - 1) - cnt;
    assign last_step = (cnt == 4'(N - 1));
    assign syn_zero  = (S1 == '0) && (S2 == '0) && (S3 == '0);

    // Chien step i locates an error at coefficient x^(14-i), the same bit order as the serial feed.
    assign flip_mask = err_hit ? ({{(N-1){1'b0}}, 1'b1} << bit_idx) : '0;
    assign work_n    = work_word ^ flip_mask;
    assign hits_n    = (err_hit && hits != HIT_SAT) ? hits + 2'd1 : hits;
    assign fail_n    = (degree == 2'd0) || (hits_n != degree);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        synd_clr    = 1'b0;
        synd_en     = 1'b0;
        synd_bit    = 1'b0;
        chien_load  = 1'b0;
        chien_en    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_err_cnt = '0;
        out_fail    = 1'b0;
        case (state)
            IDLE: begin
                synd_clr = accept;
                if (accept) state_n = SYND;
            end
            SYND: begin
                synd_en  = 1'b1;
                synd_bit = raw_word[bit_idx];
                if (last_step) state_n = CHECK;
            end
            CHECK: state_n = syn_zero ? DONE : BM;
            BM: begin
                if (wait_cnt == 3'(BM_LAT - 1)) state_n = LOAD;
            end
            LOAD: begin
                chien_load = 1'b1;
                state_n    = CHIEN;
            end
            CHIEN: begin
                chien_en = 1'b1;
                if (last_step) state_n = DONE;
            end
            DONE: begin
                out_valid   = 1'b1;
                out_data    = res_data;
                out_err_cnt = res_err_cnt;
                out_fail    = res_fail;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The result registers are written once on entry to DONE, so out_* cannot move while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_word    <= '0;
            work_word   <= '0;
            res_data    <= '0;
            cnt         <= '0;
            wait_cnt    <= '0;
            hits        <= '0;
            degree      <= '0;
            res_err_cnt <= '0;
            res_fail    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        raw_word  <= in_data;
                        work_word <= in_data;
                        cnt       <= '0;
                    end
                end
                SYND: cnt <= cnt + 4'd1;
                CHECK: begin
                    wait_cnt <= '0;
                    if (syn_zero) begin
                        res_data    <= raw_word;
                        res_err_cnt <= '0;
                        res_fail    <= 1'b0;
                    end
                end
                BM: wait_cnt <= wait_cnt + 3'd1;
                LOAD: begin
                    degree <= locator_degree(lambda1, lambda2);
                    cnt    <= '0;
                    hits   <= '0;
                end
                CHIEN: begin
                    work_word <= work_n;
                    hits      <= hits_n;
                    cnt       <= cnt + 4'd1;
                    if (last_step) begin
                        res_fail    <= fail_n;
                        res_data    <= fail_n ? raw_word : work_n;
                        res_err_cnt <= fail_n ? 2'd0 : hits_n;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCH_DEC_STATS_EN
    logic fire;
    assign fire = out_valid && out_ready;

    bch_dec_stats u_stats (
        .clk       (clk),
        .rst       (rst),
        .fire      (fire),
        .err_cnt   (res_err_cnt),
        .fail      (res_fail),
        .stat_corr (stat_corr),
        .stat_fail (stat_fail)
    );
`else
    assign stat_corr = '0;
    assign stat_fail = '0;
`endif

endmodule

// File: tb/tb_bch_dec_ctrl.sv
// Scoreboard testbench for bch_dec_ctrl: bench-side stubs stand in for the syndrome, BM and Chien units.
module tb_bch_dec_ctrl;

    localparam int BM_LAT = 2;

    typedef struct {
        logic [14:0] raw;
        logic [14:0] data;
        logic [1:0]  cnt;
        logic        fail;
        int          lat;
        int          chien;
        int          t_acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_data = '0;
    logic        synd_clr, synd_en, synd_bit;
    logic [3:0]  S1, S2, S3, lambda1, lambda2;
    logic        chien_load, chien_en;
    logic        err_hit = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [14:0] out_data;
    logic [1:0]  out_err_cnt;
    logic        out_fail;
    logic [15:0] stat_corr, stat_fail;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tmo      = 0;
    bit stall    = 1'b0;
    bit fin_req  = 1'b0;
    bit fin_done = 1'b0;

    logic [14:0] pend_raw = '0, pend_hits = '0;
    logic [3:0]  pend_s1 = '0, pend_s2 = '0, pend_s3 = '0, pend_l1 = '0, pend_l2 = '0;
    logic [14:0] act_hits = '0;
    logic [3:0]  act_s1 = '0, act_s2 = '0, act_s3 = '0, act_l1 = '0, act_l2 = '0;

    exp_t        sb_q[$];
    exp_t        cur;
    bit          in_flight = 1'b0;
    bit          seen_valid = 1'b0;
    logic [17:0] held = '0;
    logic [14:0] ser = '0;
    int          ser_n = 0;
    int          ce_cnt = 0;
    int          step = 0;
    int          m_corr = 0;
    int          m_fail = 0;

    assign S1 = act_s1;
    assign S2 = act_s2;
    assign S3 = act_s3;
    assign lambda1 = act_l1;
    assign lambda2 = act_l2;

    bch_dec_ctrl #(.BM_LAT(BM_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .synd_clr    (synd_clr),
        .synd_en     (synd_en),
        .synd_bit    (synd_bit),
        .S1          (S1),
        .S2          (S2),
        .S3          (S3),
        .lambda1     (lambda1),
        .lambda2     (lambda2),
        .chien_load  (chien_load),
        .chien_en    (chien_en),
        .err_hit     (err_hit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err_cnt (out_err_cnt),
        .out_fail    (out_fail),
        .stat_corr   (stat_corr),
        .stat_fail   (stat_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Reference model: outcome of one word from its syndromes, locator and Chien hit positions.
    function automatic exp_t modelWord(input logic [14:0] raw, input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [3:0] s3, input logic [3:0] l1, input logic [3:0] l2,
                                       input logic [14:0] hits);
        exp_t        e;
        int          deg, nh;
        logic [14:0] mask;
        e.raw   = raw;
        e.t_acc = 0;
        if (s1 == 0 && s2 == 0 && s3 == 0) begin
            e.data = raw; e.cnt = 2'd0; e.fail = 1'b0; e.lat = 17; e.chien = 0;
        end else begin
            deg  = (l2 != 0) ? 2 : ((l1 != 0) ? 1 : 0);
            nh   = $countones(hits);
            if (nh > 3) nh = 3;
            mask = '0;
            for (int i = 0; i < 15; i++) if (hits[i]) mask[14-i] = 1'b1;
            e.fail  = (deg == 0) || (nh != deg);
            e.data  = e.fail ? raw : (raw ^ mask);
            e.cnt   = e.fail ? 2'd0 : 2'(nh);
            e.lat   = 33 + BM_LAT;
            e.chien = 15;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor, scoreboard and Chien stub share one process so the queue has a single owner.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset_outputs", 64'({out_valid, in_ready, synd_clr, synd_en, synd_bit, chien_load,
                        chien_en, out_fail, out_err_cnt, out_data, stat_corr, stat_fail}), 64'd0);
            sb_q.delete();
            in_flight  = 1'b0;
            seen_valid = 1'b0;
            step       = 0;
            err_hit    = 1'b0;
            m_corr     = 0;
            m_fail     = 0;
        end else begin
            checkOutput("in_ready", 64'(in_ready), 64'(!in_flight));
            checkOutput("stat_corr", 64'(stat_corr), 64'(m_corr));
            checkOutput("stat_fail", 64'(stat_fail), 64'(m_fail));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    cur = sb_q[0];
                    if (!seen_valid) begin
                        checkOutput("latency", 64'(cyc - cur.t_acc), 64'(cur.lat));
                        held       = {out_data, out_err_cnt, out_fail};
                        seen_valid = 1'b1;
                    end else begin
                        checkOutput("hold_outputs", 64'({out_data, out_err_cnt, out_fail}), 64'(held));
                    end
                    if (out_ready) begin
                        checkOutput("out_data", 64'(out_data), 64'(cur.data));
                        checkOutput("out_err_cnt", 64'(out_err_cnt), 64'(cur.cnt));
                        checkOutput("out_fail", 64'(out_fail), 64'(cur.fail));
                        checkOutput("serial_word", 64'(ser), 64'(cur.raw));
                        checkOutput("serial_bits", 64'(ser_n), 64'd15);
                        checkOutput("chien_steps", 64'(ce_cnt), 64'(cur.chien));
`ifdef BCH_DEC_STATS_EN
                        if (cur.fail && m_fail < 65535) m_fail++;
                        if (!cur.fail && cur.cnt != 0 && m_corr < 65535) m_corr++;
`endif
                        sb_q.pop_front();
                        seen_valid = 1'b0;
                        in_flight  = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                cur       = modelWord(pend_raw, pend_s1, pend_s2, pend_s3, pend_l1, pend_l2, pend_hits);
                cur.t_acc = cyc;
                sb_q.push_back(cur);
                act_s1 = pend_s1; act_s2 = pend_s2; act_s3 = pend_s3;
                act_l1 = pend_l1; act_l2 = pend_l2; act_hits = pend_hits;
                ser = '0; ser_n = 0; ce_cnt = 0;
                in_flight = 1'b1;
            end
            if (synd_en) begin
                ser = {ser[13:0], synd_bit};
                ser_n++;
            end
            if (chien_en) ce_cnt++;
            if (chien_load) step = 0;
            if (chien_en) begin
                err_hit = (step < 15) ? act_hits[step] : 1'b0;
                step++;
            end else begin
                err_hit = 1'($urandom_range(0, 1));
            end
        end
        if (fin_req && !fin_done) begin
            checkOutput("timeouts", 64'(tmo), 64'd0);
            checkOutput("queue_empty", 64'(sb_q.size()), 64'd0);
            fin_done = 1'b1;
        end
    end

    task automatic setPending(input logic [14:0] raw, input logic [3:0] s1, input logic [3:0] s2,
                              input logic [3:0] s3, input logic [3:0] l1, input logic [3:0] l2,
                              input logic [14:0] hits);
        pend_raw = raw; pend_s1 = s1; pend_s2 = s2; pend_s3 = s3;
        pend_l1 = l1; pend_l2 = l2; pend_hits = hits;
        in_data  = raw;
        in_valid = 1'b1;
    endtask

    task automatic applyStimulus(input logic [14:0] raw, input logic [3:0] s1, input logic [3:0] s2,
                                 input logic [3:0] s3, input logic [3:0] l1, input logic [3:0] l2,
                                 input logic [14:0] hits);
        bit ok = 1'b0;
        setPending(raw, s1, s2, s3, l1, l2, hits);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 15'($urandom);
        if (!ok) tmo++;
    endtask

    task automatic waitDrain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && in_ready) ok = 1'b1;
        end
        if (!ok) tmo++;
    endtask

    initial begin
        logic [14:0] raw, hits;
        logic [3:0]  s1, s2, s3, l1, l2;
        int          nerr;
        bit          ok;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(15'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 15'h0000);
        waitDrain();
        applyStimulus(15'h0088, 4'h3, 4'h5, 4'h6, 4'h5, 4'h9, 15'h0880);
        waitDrain();
        applyStimulus(15'h0100, 4'h2, 4'h4, 4'h8, 4'h3, 4'h0, 15'h0040);
        waitDrain();
        applyStimulus(15'h0111, 4'h1, 4'h7, 4'h4, 4'h6, 4'hB, 15'h0004);
        waitDrain();

        // Hold the first result in DONE while a second word waits at the input.
        stall = 1'b1;
        applyStimulus(15'h4002, 4'h9, 4'h1, 4'hC, 4'h2, 4'h7, 15'h4001);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) ok = 1'b1;
        end
        if (!ok) tmo++;
        setPending(15'h0020, 4'h4, 4'h3, 4'h2, 4'h8, 4'h0, 15'h0200);
        repeat (5) @(posedge clk);
        #1 stall = 1'b0;
        applyStimulus(15'h0020, 4'h4, 4'h3, 4'h2, 4'h8, 4'h0, 15'h0200);
        waitDrain();

        // Abort a word in the middle of the Chien search.
        applyStimulus(15'h4001, 4'h1, 4'h2, 4'h3, 4'h7, 4'h2, 15'h4001);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (chien_en && step == 5) ok = 1'b1;
        end
        if (!ok) tmo++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(15'h1008, 4'h6, 4'hA, 4'h3, 4'h1, 4'hE, 15'h0802);
        waitDrain();

        for (int w = 0; w < 40; w++) begin
            raw = 15'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                s1 = 4'h0; s2 = 4'h0; s3 = 4'h0;
            end else begin
                s1 = 4'($urandom_range(1, 15)); s2 = 4'($urandom); s3 = 4'($urandom);
            end
            nerr = $urandom_range(0, 3);
            hits = '0;
            for (int k = 0; k < nerr; k++) hits[$urandom_range(0, 14)] = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                l1 = 4'($urandom_range(1, 15));
                l2 = (nerr >= 2) ? 4'($urandom_range(1, 15)) : 4'h0;
            end else begin
                l1 = 4'($urandom);
                l2 = 4'($urandom);
            end
            applyStimulus(raw, s1, s2, s3, l1, l2, hits);
        end
        waitDrain();

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_done; i++) @(negedge clk);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
